// File: rtl/nrisc_pkg.sv
// Shared definitions for the nrisc call/return path: sequencer state encoding,
// stack control strobe codes and default PC width / stack depth.
package nrisc_pkg;

    localparam int TAM_DEF    = 16;
    localparam int NSTACK_DEF = 8;

    typedef enum logic [1:0] {
        CC_IDLE = 2'd0,
        CC_PUSH = 2'd1,
        CC_POP  = 2'd2,
        CC_GAP  = 2'd3
    } cc_state_t;

    localparam logic [1:0] CTRL_NONE = 2'b00;
    localparam logic [1:0] CTRL_PUSH = 2'b01;
    localparam logic [1:0] CTRL_POP  = 2'b10;

endpackage

// File: rtl/call_ctrl_depth_cnt.sv
// Saturating up/down counter tracking how many entries the return stack holds.
// Full/empty flags are decoded from the registered count.
module call_ctrl_depth_cnt #(
    parameter int NStack = 8,
    parameter int DW     = $clog2(NStack + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_inc,
    input  logic          i_dec,
    output logic [DW-1:0] o_count,
    output logic          o_full,
    output logic          o_empty
);

    localparam logic [DW-1:0] MAX_CNT = DW'(NStack);
    localparam logic [DW-1:0] ONE_CNT = {{(DW-1){1'b0}}, 1'b1};

    logic [DW-1:0] r_count;

    // Count moves by one per accepted push/pop and never wraps past 0 or NStack.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_count <= {DW{1'b0}};
        end else if (i_inc && !i_dec && (r_count != MAX_CNT)) begin
            r_count <= r_count + ONE_CNT;
        end else if (i_dec && !i_inc && (r_count != {DW{1'b0}})) begin
            r_count <= r_count - ONE_CNT;
        end else begin
            r_count <= r_count;
        end
    end

    assign o_count = r_count;
    assign o_full  = (r_count == MAX_CNT);
    assign o_empty = (r_count == {DW{1'b0}});

endmodule

// File: rtl/call_ctrl.sv
// Call/return sequencer: turns CALL/RET/IRQ requests into single-cycle push/pop
// strobes for the return stack, selects the next PC and tracks stack depth.
module call_ctrl
    import nrisc_pkg::*;
#(
    parameter int TAM    = TAM_DEF,
    parameter int NStack = NSTACK_DEF,
    parameter int DW     = $clog2(NStack + 1)
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           call,
    input  logic           ret,
    input  logic           irq,
    input  logic [TAM-1:0] target,
    input  logic [TAM-1:0] irqVector,
    input  logic [TAM-1:0] pc,
    input  logic [2:0]     flags,
    input  logic [TAM-1:0] stackPC,
    input  logic [2:0]     stackFlags,
    output logic [1:0]     ctrl,
    output logic [TAM-1:0] pushPC,
    output logic [2:0]     pushFlags,
    output logic           pcLoad,
    output logic [TAM-1:0] pcNext,
    output logic           flagsLoad,
    output logic [2:0]     flagsRestore,
    output logic           busy,
    output logic [DW-1:0]  depth,
    output logic           overflow,
    output logic           underflow,
    output logic           irqMask
);

    cc_state_t      r_state;
    logic [1:0]     r_ctrl;
    logic [TAM-1:0] r_push_pc;
    logic [2:0]     r_push_flags;
    logic           r_pc_load;
    logic [TAM-1:0] r_pc_next;
    logic           r_flags_load;
    logic [2:0]     r_flags_restore;
    logic           r_busy;
    logic           r_overflow;
    logic           r_underflow;
    logic           r_irq_mask;

    logic           w_full;
    logic           w_empty;
    logic [DW-1:0]  w_depth;
    logic [TAM-1:0] w_pc_inc;
    logic           w_take_irq;
    logic           w_take_ret;
    logic           w_take_call;
    logic           w_ovf_set;
    logic           w_unf_set;

    assign w_pc_inc = pc + {{(TAM-1){1'b0}}, 1'b1};

    // Request arbitration in IDLE; a refused winner blocks lower priorities this cycle.
    always_comb begin
        w_take_irq  = 1'b0;
        w_take_ret  = 1'b0;
        w_take_call = 1'b0;
        w_ovf_set   = 1'b0;
        w_unf_set   = 1'b0;
        if (r_state == CC_IDLE) begin
            if (irq && !r_irq_mask) begin
                if (w_full) begin
                    w_ovf_set = 1'b1;
                end else begin
                    w_take_irq = 1'b1;
                end
            end else if (ret) begin
                if (w_empty) begin
                    w_unf_set = 1'b1;
                end else begin
                    w_take_ret = 1'b1;
                end
            end else if (call) begin
                if (w_full) begin
                    w_ovf_set = 1'b1;
                end else begin
                    w_take_call = 1'b1;
                end
            end else begin
                w_take_irq = 1'b0;
            end
        end else begin
            w_take_irq = 1'b0;
        end
    end

    call_ctrl_depth_cnt #(
        .NStack (NStack),
        .DW     (DW)
    ) u_depth_cnt (
        .clk     (clk),
        .rst     (rst),
        .i_inc   (w_take_irq | w_take_call),
        .i_dec   (w_take_ret),
        .o_count (w_depth),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    // Sequencer FSM: strobes are registered on entry to PUSH/POP and dropped in GAP.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state         <= CC_IDLE;
            r_ctrl          <= CTRL_NONE;
            r_push_pc       <= {TAM{1'b0}};
            r_push_flags    <= 3'b000;
            r_pc_load       <= 1'b0;
            r_pc_next       <= {TAM{1'b0}};
            r_flags_load    <= 1'b0;
            r_flags_restore <= 3'b000;
            r_busy          <= 1'b0;
            r_overflow      <= 1'b0;
            r_underflow     <= 1'b0;
            r_irq_mask      <= 1'b0;
        end else begin
            r_overflow  <= r_overflow | w_ovf_set;
            r_underflow <= r_underflow | w_unf_set;
            case (r_state)
                CC_IDLE: begin
                    if (w_take_irq || w_take_call) begin
                        r_push_pc    <= w_take_irq ? pc : w_pc_inc;
                        r_push_flags <= flags;
                        r_pc_next    <= w_take_irq ? irqVector : target;
                        r_irq_mask   <= r_irq_mask | w_take_irq;
                        r_ctrl       <= CTRL_PUSH;
                        r_pc_load    <= 1'b1;
                        r_flags_load <= 1'b0;
                        r_busy       <= 1'b1;
                        r_state      <= CC_PUSH;
                    end else if (w_take_ret) begin
                        r_pc_next       <= stackPC;
                        r_flags_restore <= stackFlags;
                        r_irq_mask      <= 1'b0;
                        r_ctrl          <= CTRL_POP;
                        r_pc_load       <= 1'b1;
                        r_flags_load    <= 1'b1;
                        r_busy          <= 1'b1;
                        r_state         <= CC_POP;
                    end else begin
                        r_ctrl       <= CTRL_NONE;
                        r_pc_load    <= 1'b0;
                        r_flags_load <= 1'b0;
                        r_busy       <= 1'b0;
                        r_state      <= CC_IDLE;
                    end
                end
                CC_PUSH, CC_POP: begin
                    r_ctrl       <= CTRL_NONE;
                    r_pc_load    <= 1'b0;
                    r_flags_load <= 1'b0;
                    r_busy       <= 1'b1;
                    r_state      <= CC_GAP;
                end
                CC_GAP: begin
                    r_ctrl       <= CTRL_NONE;
                    r_pc_load    <= 1'b0;
                    r_flags_load <= 1'b0;
                    r_busy       <= 1'b0;
                    r_state      <= CC_IDLE;
                end
                default: begin
                    r_ctrl       <= CTRL_NONE;
                    r_pc_load    <= 1'b0;
                    r_flags_load <= 1'b0;
                    r_busy       <= 1'b0;
                    r_state      <= CC_IDLE;
                end
            endcase
        end
    end

    assign ctrl         = r_ctrl;
    assign pushPC       = r_push_pc;
    assign pushFlags    = r_push_flags;
    assign pcLoad       = r_pc_load;
    assign pcNext       = r_pc_next;
    assign flagsLoad    = r_flags_load;
    assign flagsRestore = r_flags_restore;
    assign busy         = r_busy;
    assign depth        = w_depth;
    assign overflow     = r_overflow;
    assign underflow    = r_underflow;
    assign irqMask      = r_irq_mask;

endmodule

// File: tb/tb_call_ctrl.sv
// Scoreboard bench for call_ctrl: a transaction-level stack model predicts each
// push/pop event; a negedge monitor pops and compares whenever the DUT strobes.
module tb_call_ctrl;

    localparam int TAM    = 16;
    localparam int NSTACK = 8;

    typedef struct {
        logic        pop;
        logic [15:0] pc_next;
        logic [15:0] push_pc;
        logic [2:0]  push_flags;
        logic [2:0]  fl_restore;
        int          depth;
        logic        mask;
    } ev_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        call, ret, irq;
    logic [15:0] target, irqVector, pc, stackPC;
    logic [2:0]  flags, stackFlags;
    logic [1:0]  ctrl;
    logic [15:0] pushPC, pcNext;
    logic [2:0]  pushFlags, flagsRestore;
    logic        pcLoad, flagsLoad, busy, overflow, underflow, irqMask;
    logic [3:0]  depth;

    int unsigned n_cmp = 0;
    int unsigned n_err = 0;
    bit          mon_en = 1'b0;

    // Reference model state: stack contents, cycles until idle, sticky flags.
    logic [18:0] m_stack[$];
    int          m_cool = 0;
    logic        m_mask = 1'b0;
    logic        m_ovf = 1'b0;
    logic        m_unf = 1'b0;
    ev_t         exp_q[$];

    always #5 clk = ~clk;

    call_ctrl dut (
        .clk(clk), .rst(rst), .call(call), .ret(ret), .irq(irq),
        .target(target), .irqVector(irqVector), .pc(pc), .flags(flags),
        .stackPC(stackPC), .stackFlags(stackFlags), .ctrl(ctrl),
        .pushPC(pushPC), .pushFlags(pushFlags), .pcLoad(pcLoad), .pcNext(pcNext),
        .flagsLoad(flagsLoad), .flagsRestore(flagsRestore), .busy(busy),
        .depth(depth), .overflow(overflow), .underflow(underflow), .irqMask(irqMask)
    );

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] expv);
        n_cmp++;
        if (act !== expv) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h at %0t", nm, act, expv, $time);
        end
    endtask

    task automatic do_push(input logic [15:0] ppc, input logic [2:0] pfl, input logic [15:0] nxt);
        ev_t e;
        m_stack.push_back({ppc, pfl});
        m_cool       = 2;
        e.pop        = 1'b0;
        e.pc_next    = nxt;
        e.push_pc    = ppc;
        e.push_flags = pfl;
        e.fl_restore = 3'b000;
        e.depth      = m_stack.size();
        e.mask       = m_mask;
        exp_q.push_back(e);
    endtask

    task automatic do_pop();
        ev_t         e;
        logic [18:0] top;
        top          = m_stack.pop_back();
        m_mask       = 1'b0;
        m_cool       = 2;
        e.pop        = 1'b1;
        e.pc_next    = top[18:3];
        e.push_pc    = 16'h0000;
        e.push_flags = 3'b000;
        e.fl_restore = top[2:0];
        e.depth      = m_stack.size();
        e.mask       = m_mask;
        exp_q.push_back(e);
    endtask

    // Apply the sequencer rules to the inputs that were present at the last edge.
    task automatic model_step();
        if (!rst) begin
            m_stack.delete();
            exp_q.delete();
            m_cool = 0;
            m_mask = 1'b0;
            m_ovf  = 1'b0;
            m_unf  = 1'b0;
        end else if (m_cool > 0) begin
            m_cool--;
        end else if (irq && !m_mask) begin
            if (m_stack.size() == NSTACK) m_ovf = 1'b1;
            else begin
                m_mask = 1'b1;
                do_push(pc, flags, irqVector);
            end
        end else if (ret) begin
            if (m_stack.size() == 0) m_unf = 1'b1;
            else do_pop();
        end else if (call) begin
            if (m_stack.size() == NSTACK) m_ovf = 1'b1;
            else do_push(pc + 16'h0001, flags, target);
        end
    endtask

    task automatic drive_stack();
        if (m_stack.size() > 0) {stackPC, stackFlags} = m_stack[$];
        else begin
            stackPC    = 16'($urandom);
            stackFlags = 3'($urandom);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        model_step();
        drive_stack();
    endtask

    task automatic rand_inputs(input int wc, input int wr, input int wi);
        call      = ($urandom_range(99) < 32'(wc));
        ret       = ($urandom_range(99) < 32'(wr));
        irq       = ($urandom_range(99) < 32'(wi));
        rst       = ($urandom_range(399) != 0);
        pc        = 16'($urandom);
        target    = 16'($urandom);
        irqVector = 16'($urandom);
        flags     = 3'($urandom);
    endtask

    task automatic idle_inputs();
        call = 1'b0;
        ret  = 1'b0;
        irq  = 1'b0;
    endtask

    // Monitor: pop an expected event whenever one is due or the DUT strobes.
    always @(negedge clk) begin
        if (mon_en) begin
            if (exp_q.size() > 0) begin
                ev_t e;
                e = exp_q.pop_front();
                check("ev_ctrl", 32'(ctrl), e.pop ? 32'd2 : 32'd1);
                check("ev_pcLoad", 32'(pcLoad), 32'd1);
                check("ev_flagsLoad", 32'(flagsLoad), 32'(e.pop));
                check("ev_pcNext", 32'(pcNext), 32'(e.pc_next));
                check("ev_depth", 32'(depth), 32'(e.depth));
                check("ev_irqMask", 32'(irqMask), 32'(e.mask));
                if (e.pop) begin
                    check("ev_flagsRestore", 32'(flagsRestore), 32'(e.fl_restore));
                end else begin
                    check("ev_pushPC", 32'(pushPC), 32'(e.push_pc));
                    check("ev_pushFlags", 32'(pushFlags), 32'(e.push_flags));
                end
            end else begin
                check("quiet_strobes", {29'd0, ctrl, pcLoad | flagsLoad}, 32'd0);
            end
            check("busy", 32'(busy), 32'(m_cool > 0));
            check("depth", 32'(depth), 32'(m_stack.size()));
            check("overflow", 32'(overflow), 32'(m_ovf));
            check("underflow", 32'(underflow), 32'(m_unf));
            check("irqMask", 32'(irqMask), 32'(m_mask));
        end
    end

    initial begin
        rst = 1'b0; call = 1'b1; ret = 1'b1; irq = 1'b1;
        pc = 16'h1234; target = 16'h5678; irqVector = 16'h9abc; flags = 3'b111;
        drive_stack();
        tick();
        mon_en = 1'b1;
        tick();
        check("rst_pcNext", 32'(pcNext), 32'd0);
        check("rst_pushPC", 32'(pushPC), 32'd0);
        check("rst_pushFlags", 32'(pushFlags), 32'd0);
        check("rst_flagsRestore", 32'(flagsRestore), 32'd0);

        // CALL then RET with the documented values
        rst = 1'b1; idle_inputs();
        pc = 16'h0100; target = 16'h0400; flags = 3'b101; call = 1'b1;
        tick(); call = 1'b0; tick(); tick();
        ret = 1'b1; flags = 3'b000;
        tick(); ret = 1'b0; tick(); tick();

        // irq beats call; a masked irq is ignored until RET
        pc = 16'h0200; irqVector = 16'h0800; irq = 1'b1; call = 1'b1;
        tick(); irq = 1'b0; call = 1'b0; tick(); tick();
        irq = 1'b1;
        repeat (4) tick();
        irq = 1'b0; ret = 1'b1;
        tick(); ret = 1'b0; tick(); tick();

        // Fill to overflow with call held high, then drain to underflow
        call = 1'b1;
        for (int i = 0; i < 30; i++) begin
            pc = 16'($urandom); target = 16'($urandom); flags = 3'($urandom);
            tick();
        end
        call = 1'b0; ret = 1'b1;
        repeat (30) tick();
        ret = 1'b0; tick();

        // Reset arriving during PUSH
        call = 1'b1; pc = 16'hfffe; target = 16'h0010;
        tick(); rst = 1'b0; call = 1'b0;
        tick(); rst = 1'b1;
        tick();

        for (int ph = 0; ph < 4; ph++) begin
            for (int i = 0; i < 500; i++) begin
                case (ph)
                    0:       rand_inputs(60, 15, 10);
                    1:       rand_inputs(15, 60, 10);
                    2:       rand_inputs(40, 40, 20);
                    default: rand_inputs(20, 20, 60);
                endcase
                tick();
            end
        end

        rst = 1'b1; idle_inputs();
        repeat (4) tick();
        @(negedge clk);
        #1;
        check("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
